// File: rtl/dmem_mmio_if.sv
// dmem_mmio_if: load/store port between the rv32i core and dmem_mmio.
// Master is the core, slave is the memory; rd is combinational from the slave.
interface dmem_mmio_if #(
   parameter int AW = 8
) ();
   logic          we;
   logic [1:0]    size;
   logic [AW-1:0] addr;
   logic [31:0]   wd;
   logic [31:0]   rd;

   modport master (output we, size, addr, wd, input rd);
   modport slave  (input we, size, addr, wd, output rd);
endinterface

// File: rtl/dmem_mmio.sv
// dmem_mmio: byte-addressed data RAM with a KEY / IRQ / LED register window on top.
// Define DMEM_DEBOUNCE_EN to add a per-key debounce counter in front of KEY_DATA.
module dmem_mmio #(
   parameter int DEPTH   = 64,
   parameter int IO_BASE = 56,
   parameter int N_LED   = 2,
   parameter int KEY_W   = 4,
   parameter int DEB_CYC = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   dmem_mmio_if.slave          bus,
   input  logic [KEY_W-1:0]    key,
   output logic [32*N_LED-1:0] led,
   output logic                irq
);
   localparam int WW = $clog2(DEPTH);
   localparam int RW = (IO_BASE > 1) ? $clog2(IO_BASE) : 1;
   localparam logic [WW-1:0] IO_BASE_W = WW'(IO_BASE);

   // Byte enables for an aligned access; misaligned or size 11 yields no lanes.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] m;
      case (size)
         2'b00:   m = 4'b0001 << lane;
         2'b01:   m = lane[0] ? 4'b0000 : (lane[1] ? 4'b1100 : 4'b0011);
         2'b10:   m = (lane == 2'b00) ? 4'b1111 : 4'b0000;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
      logic [31:0] d;
      case (size)
         2'b00:   d = {4{wd[7:0]}};
         2'b01:   d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

   logic [31:0]      mem_r [IO_BASE];
   logic [31:0]      led_r [N_LED];
   logic [KEY_W-1:0] sync1_r, sync2_r, key_data_r, status_r, enable_r;
   logic [KEY_W-1:0] key_data_nxt_s, rise_s, clr_s;
   logic [WW-1:0]    w_s, io_off_s;
   logic [3:0]       bmask_s;
   logic [31:0]      wmask_s, wdata_s, rd_s, led_rd_s;
   logic             ram_we_s, io_we_s;

   // Address decode and write-lane formation.
   always_comb begin
      w_s      = bus.addr[WW+1:2];
      io_off_s = w_s - IO_BASE_W;
      bmask_s  = lane_mask(bus.size, bus.addr[1:0]);
      wmask_s  = {{8{bmask_s[3]}}, {8{bmask_s[2]}}, {8{bmask_s[1]}}, {8{bmask_s[0]}}};
      wdata_s  = lane_data(bus.size, bus.wd);
      if (bus.we && (bmask_s != 4'b0000)) begin
         ram_we_s = (w_s < IO_BASE_W);
         io_we_s  = (w_s >= IO_BASE_W);
      end else begin
         ram_we_s = 1'b0;
         io_we_s  = 1'b0;
      end
   end

   // RAM byte-lane writes; the array has no reset.
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         for (int b = 0; b < 4; b++) begin
            if (bmask_s[b]) begin
               mem_r[w_s[RW-1:0]][8*b +: 8] <= wdata_s[8*b +: 8];
            end
         end
      end
   end

`ifdef DMEM_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_CYC + 1);
   logic [CW-1:0] deb_cnt_r [KEY_W];

   // Count consecutive cycles where the synchronised key disagrees with KEY_DATA.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < KEY_W; i++) deb_cnt_r[i] <= '0;
      end else begin
         for (int i = 0; i < KEY_W; i++) begin
            if ((sync2_r[i] != key_data_r[i]) && (deb_cnt_r[i] != CW'(DEB_CYC))) begin
               deb_cnt_r[i] <= deb_cnt_r[i] + CW'(1);
            end else begin
               deb_cnt_r[i] <= '0;
            end
         end
      end
   end

   // A bit flips only once the disagreement has lasted DEB_CYC cycles.
   always_comb begin
      key_data_nxt_s = key_data_r;
      for (int i = 0; i < KEY_W; i++) begin
         key_data_nxt_s[i] = ((sync2_r[i] != key_data_r[i]) && (deb_cnt_r[i] == CW'(DEB_CYC)))
                             ? sync2_r[i] : key_data_r[i];
      end
   end
`else
   assign key_data_nxt_s = sync2_r;
`endif

   // Rising KEY_DATA edges set status; a W1C store clears, with set taking priority.
   always_comb begin
      rise_s = key_data_nxt_s & ~key_data_r;
      if (io_we_s && (io_off_s == WW'(1))) begin
         clr_s = wdata_s[KEY_W-1:0] & wmask_s[KEY_W-1:0];
      end else begin
         clr_s = '0;
      end
   end

   // Key synchroniser, KEY_DATA, IRQ and LED registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r    <= '0;
         sync2_r    <= '0;
         key_data_r <= '0;
         status_r   <= '0;
         enable_r   <= '0;
         for (int k = 0; k < N_LED; k++) led_r[k] <= 32'h0;
      end else begin
         sync1_r    <= key;
         sync2_r    <= sync1_r;
         key_data_r <= key_data_nxt_s;
         status_r   <= (status_r & ~clr_s) | rise_s;
         if (io_we_s && (io_off_s == WW'(2))) begin
            enable_r <= (enable_r & ~wmask_s[KEY_W-1:0]) | (wdata_s[KEY_W-1:0] & wmask_s[KEY_W-1:0]);
         end else begin
            enable_r <= enable_r;
         end
         for (int k = 0; k < N_LED; k++) begin
            if (io_we_s && (io_off_s == WW'(3 + k))) begin
               led_r[k] <= (led_r[k] & ~wmask_s) | (wdata_s & wmask_s);
            end else begin
               led_r[k] <= led_r[k];
            end
         end
      end
   end

   // Combinational read of the aligned word; unmapped I/O words read zero.
   always_comb begin
      rd_s     = 32'h0;
      led_rd_s = 32'h0;
      for (int k = 0; k < N_LED; k++) begin
         led_rd_s = led_rd_s | ((io_off_s == WW'(3 + k)) ? led_r[k] : 32'h0);
      end
      if (w_s < IO_BASE_W) begin
         rd_s = mem_r[w_s[RW-1:0]];
      end else begin
         case (io_off_s)
            WW'(0):  rd_s[KEY_W-1:0] = key_data_r;
            WW'(1):  rd_s[KEY_W-1:0] = status_r;
            WW'(2):  rd_s[KEY_W-1:0] = enable_r;
            default: rd_s = led_rd_s;
         endcase
      end
   end

   assign bus.rd = rd_s;
   assign irq    = |(status_r & enable_r);

   // Flatten LED registers onto the output bus.
   always_comb begin
      led = '0;
      for (int k = 0; k < N_LED; k++) led[32*k +: 32] = led_r[k];
   end
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed and randomized checks of dmem_mmio against a behavioural model.
// The model keeps RAM words, I/O registers and a key delay line, updated on every clock.
module tb_dmem_mmio;
   localparam int DEPTH = 64, IO_BASE = 56, N_LED = 2, KEY_W = 4, DEB_CYC = 16, AW = 8;
   localparam logic [7:0] A_KEY = 8'hE0, A_STAT = 8'hE4, A_EN = 8'hE8;
   localparam logic [7:0] A_LED0 = 8'hEC, A_LED1 = 8'hF0, A_HOLE = 8'hF4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [KEY_W-1:0] key = '0;
   logic [63:0]      led;
   logic             irq;
   int               total = 0;
   int               bad = 0;

   dmem_mmio_if #(.AW(AW)) bus ();

   dmem_mmio #(.DEPTH(DEPTH), .IO_BASE(IO_BASE), .N_LED(N_LED), .KEY_W(KEY_W), .DEB_CYC(DEB_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .key(key), .led(led), .irq(irq)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [31:0]      m_ram [IO_BASE];
   logic [31:0]      m_led [N_LED];
   logic [KEY_W-1:0] m_kd, m_stat, m_en;
   logic [KEY_W-1:0] m_kh [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply one clock edge of the specified behaviour to the model.
   task automatic m_edge();
      logic [KEY_W-1:0] kd_new, clr;
      logic [31:0]      bm, ad;
      int               w, lane, nb;
      bit               ok;
      if (!rst_n) begin
         m_kd = '0; m_stat = '0; m_en = '0; m_kh[0] = '0; m_kh[1] = '0;
         for (int k = 0; k < N_LED; k++) m_led[k] = 32'h0;
         return;
      end
      lane = int'(bus.addr[1:0]);
      w    = int'(bus.addr) / 4;
      ok   = bus.we && ((bus.size == 2'd0) || (bus.size == 2'd1 && lane % 2 == 0) ||
                        (bus.size == 2'd2 && lane == 0));
      nb   = (bus.size == 2'd0) ? 1 : (bus.size == 2'd1) ? 2 : 4;
      bm = 32'h0; ad = 32'h0; clr = '0;
      for (int b = 0; b < 4; b++) begin
         if (ok && b >= lane && b < lane + nb) begin
            bm[8*b +: 8] = 8'hFF;
            ad[8*b +: 8] = bus.wd[8*(b-lane) +: 8];
         end
      end
      if (ok && w < IO_BASE) m_ram[w] = (m_ram[w] & ~bm) | (ad & bm);
      else if (ok) begin
         case (w - IO_BASE)
            1:       clr = ad[KEY_W-1:0] & bm[KEY_W-1:0];
            2:       m_en = (m_en & ~bm[KEY_W-1:0]) | (ad[KEY_W-1:0] & bm[KEY_W-1:0]);
            3, 4:    m_led[w-IO_BASE-3] = (m_led[w-IO_BASE-3] & ~bm) | (ad & bm);
            default: ;
         endcase
      end
      kd_new  = m_kh[1];
      m_kh[1] = m_kh[0];
      m_kh[0] = key;
      m_stat  = (m_stat & ~clr) | (kd_new & ~m_kd);
      m_kd    = kd_new;
   endtask

   function automatic logic [31:0] m_rd(input logic [7:0] a);
      int          w;
      logic [31:0] r;
      w = int'(a) / 4;
      r = 32'h0;
      if (w < IO_BASE) r = m_ram[w];
      else begin
         case (w - IO_BASE)
            0:       r[KEY_W-1:0] = m_kd;
            1:       r[KEY_W-1:0] = m_stat;
            2:       r[KEY_W-1:0] = m_en;
            3:       r = m_led[0];
            4:       r = m_led[1];
            default: r = 32'h0;
         endcase
      end
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      m_edge();
      @(negedge clk);
   endtask

   task automatic drive(input bit we, input logic [1:0] sz, input logic [7:0] a, input logic [31:0] d);
      bus.we = we; bus.size = sz; bus.addr = a; bus.wd = d;
   endtask

   task automatic store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] d);
      drive(1'b1, sz, a, d);
      cyc();
      bus.we = 1'b0;
   endtask

   task automatic peek(input logic [7:0] a, output logic [31:0] v);
      bus.we = 1'b0; bus.addr = a;
      #1 v = bus.rd;
   endtask

   initial begin
      logic [31:0] v;
      logic [7:0]  a;

      // Reset with keys high and a store pending
      drive(1'b1, 2'b10, A_LED0, 32'hFFFF_FFFF);
      key = 4'hF;
      repeat (3) cyc();
      chk("rst_led", led, 64'h0);
      chk("rst_irq", irq, 1'b0);
      bus.addr = A_KEY;
      #1 chk("rst_keydata", bus.rd, 32'h0);
      @(negedge clk);
      key = '0; bus.we = 1'b0; rst_n = 1'b1;
      repeat (3) cyc();
      chk("post_rst_led", led, 64'h0);

      for (int i = 0; i < IO_BASE; i++) store(2'b10, 8'(i * 4), $urandom);

      // Byte / half / word lanes and misaligned drops
      store(2'b10, 8'h10, 32'hA5A5_A5A5);
      store(2'b00, 8'h11, 32'h0000_003C);
      store(2'b01, 8'h12, 32'h0000_BEEF);
      peek(8'h10, v); chk("lanes", v, 32'hBEEF_3CA5);
      store(2'b01, 8'h11, 32'h0000_DEAD);
      peek(8'h10, v); chk("mis_half", v, 32'hBEEF_3CA5);
      store(2'b10, 8'h12, 32'h0);
      peek(8'h10, v); chk("mis_word", v, 32'hBEEF_3CA5);

      // Same-cycle read sees old data, next cycle sees new
      drive(1'b1, 2'b10, 8'h10, 32'h1111_1111);
      #1 chk("same_cyc_old", bus.rd, 32'hBEEF_3CA5);
      cyc(); bus.we = 1'b0;
      peek(8'h10, v); chk("next_cyc_new", v, 32'h1111_1111);

      // LEDs
      store(2'b10, A_LED1, 32'h1234_5678);
      chk("led1", led[63:32], 32'h1234_5678);
      chk("led0_zero", led[31:0], 32'h0);
      peek(A_LED1, v); chk("led1_rd", v, 32'h1234_5678);
      store(2'b00, 8'hEE, 32'h0000_00AB);
      chk("led0_byte", led[31:0], 32'h00AB_0000);

      // Unmapped words and enable width
      store(2'b10, A_HOLE, 32'hFFFF_FFFF);
      peek(A_HOLE, v); chk("hole", v, 32'h0);
      store(2'b10, A_EN, 32'hFFFF_FFFF);
      peek(A_EN, v); chk("en_width", v, 32'h0000_000F);
      store(2'b10, A_EN, 32'h1);

`ifndef DMEM_DEBOUNCE_EN
      // Rising key edge -> status and irq after the third posedge
      key[0] = 1'b1;
      cyc(); cyc();
      chk("irq_early", irq, 1'b0);
      cyc();
      chk("irq_set", irq, 1'b1);
      peek(A_STAT, v); chk("stat_set", v, 32'h1);
      peek(A_KEY, v); chk("keydata", v, 32'h1);
      store(2'b10, A_STAT, 32'h1);
      chk("irq_w1c", irq, 1'b0);
      store(2'b10, A_KEY, 32'h0);
      peek(A_KEY, v); chk("key_ro", v, 32'h1);
      key[0] = 1'b0;
      repeat (4) cyc();
      chk("fall_noirq", irq, 1'b0);
      peek(A_STAT, v); chk("fall_stat", v, 32'h0);
      // New rising edge on the same clock as a W1C of that bit
      key[0] = 1'b1;
      cyc(); cyc();
      store(2'b10, A_STAT, 32'h1);
      peek(A_STAT, v); chk("set_wins", v, 32'h1);
      store(2'b10, A_EN, 32'h0);
      chk("irq_disable", irq, 1'b0);
      store(2'b10, A_STAT, 32'hF);
`endif

      // Randomized traffic against the model
      for (int it = 0; it < 300; it++) begin
`ifndef DMEM_DEBOUNCE_EN
         if ($urandom_range(0, 3) == 0) key = KEY_W'($urandom);
`endif
         a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, IO_BASE * 4 - 1))
                                         : 8'($urandom_range(IO_BASE * 4, 255));
         drive(1'($urandom_range(0, 1)), 2'($urandom), a, $urandom);
         cyc();
         bus.we = 1'b0;
         a = 8'($urandom);
         peek(a, v);
         chk("rand_rd", v, m_rd(a));
         chk("rand_irq", irq, |(m_stat & m_en));
         chk("rand_led", led, {m_led[1], m_led[0]});
      end

`ifdef DMEM_DEBOUNCE_EN
      key = '0;
      repeat (40) cyc();
      store(2'b10, A_STAT, 32'hF);
      store(2'b10, A_EN, 32'h1);
      key[0] = 1'b1;
      repeat (10) cyc();
      key[0] = 1'b0;
      repeat (30) cyc();
      peek(A_STAT, v); chk("deb_glitch_stat", v, 32'h0);
      peek(A_KEY, v); chk("deb_glitch_kd", v, 32'h0);
      key[0] = 1'b1;
      repeat (18) cyc();
      peek(A_KEY, v); chk("deb_kd_early", v, 32'h0);
      cyc();
      peek(A_KEY, v); chk("deb_kd_set", v, 32'h1);
      peek(A_STAT, v); chk("deb_stat_set", v, 32'h1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
